year_bin2bcd: RTL and testbench

Sequential binary-to-BCD converter for the calendar year path. It takes a 14-bit binary year, such as the packed year value or a year entered from switches, and converts it to four BCD digits with a shift-add-3 (double-dabble) state machine. It drives the four BCD digits and their 7-segment patterns, and handshakes with the requester through `start`, `busy` and `done`. It is the inverse of the year counter's BCD-to-binary packing and lets a binary year be loaded back into digit form.

---
 rtl/year_bin2bcd_if.sv | 28 ++
 rtl/year_bin2bcd.sv | 118 +++++++++++
 tb/tb_year_bin2bcd.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/year_bin2bcd_if.sv
// Request/result bundle for the binary-year to BCD converter.
// Handshake: the requester raises start with year_bin stable; it is accepted on the first
// rising edge that sees start=1 while busy=0, and done pulses for one cycle when the digits update.
interface year_bin2bcd_if #(
  parameter int IN_BITS = 14
);
  logic               start;
  logic [IN_BITS-1:0] year_bin;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [3:0]         digit0;
  logic [3:0]         digit1;
  logic [3:0]         digit2;
  logic [3:0]         digit3;
  logic [27:0]        year_7seg;
  logic               state_dbg;

  modport master (
    output start, year_bin,
    input  busy, done, overflow, digit0, digit1, digit2, digit3, year_7seg, state_dbg
  );

  modport slave (
    input  start, year_bin,
    output busy, done, overflow, digit0, digit1, digit2, digit3, year_7seg, state_dbg
  );
endinterface

// File: rtl/year_bin2bcd.sv
// Sequential shift-add-3 converter from a binary year to four BCD digits plus
// their 7-segment patterns; one bit is consumed per clock while busy.
module year_bin2bcd #(
  parameter int IN_BITS  = 14,
  parameter int MAX_YEAR = 9999
) (
  input  logic            clock_in0,
  input  logic            reset,
  year_bin2bcd_if.slave   bus
);
  localparam int CNT_W = $clog2(IN_BITS + 1);
  localparam logic [IN_BITS-1:0] MAX_BIN = IN_BITS'(MAX_YEAR);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IN_BITS-1:0] bin_q, bin_d;
  logic [15:0]        scr_q, scr_d, scr_corr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        dig_q, dig_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Each nibble is corrected from its own pre-correction value; 9+3 never exceeds 4 bits.
  always_comb begin
    scr_corr = '0;
    for (int i = 0; i < 4; i++) begin
      scr_corr[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3
                                                       : scr_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.year_bin > MAX_BIN) begin
            bin_d = MAX_BIN;
            ovf_d = 1'b1;
          end else begin
            bin_d = bus.year_bin;
            ovf_d = 1'b0;
          end
          scr_d   = '0;
          cnt_d   = CNT_W'(IN_BITS);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, bin_d} = {scr_corr, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
        // Last iteration: publish the shifted scratch directly so digits move only once.
        if (cnt_q == CNT_W'(1)) begin
          dig_d   = {scr_corr[14:0], bin_q[IN_BITS-1]};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in0 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= 16'h0001;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.digit0    = dig_q[3:0];
  assign bus.digit1    = dig_q[7:4];
  assign bus.digit2    = dig_q[11:8];
  assign bus.digit3    = dig_q[15:12];
  assign bus.year_7seg = {seg7(dig_q[15:12]), seg7(dig_q[11:8]),
                          seg7(dig_q[7:4]), seg7(dig_q[3:0])};
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_year_bin2bcd.sv
// Directed bench for year_bin2bcd: driver tasks push expected {overflow, digits} into a
// queue at each accepting edge; a negedge monitor pops and compares whenever done is high.
module tb_year_bin2bcd;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [16:0] exp_q[$];

  year_bin2bcd_if #(.IN_BITS(14)) bus ();

  year_bin2bcd #(.IN_BITS(14), .MAX_YEAR(9999)) dut (
    .clock_in0 (clk),
    .reset     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d <= 4'd9) ? tbl[d] : 7'h00;
  endfunction

  function automatic logic [27:0] seg_word(input logic [15:0] bcd);
    return {seg_ref(bcd[15:12]), seg_ref(bcd[11:8]), seg_ref(bcd[7:4]), seg_ref(bcd[3:0])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_digits();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending conversion");
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("digits", {16'h0, dut_digits()}, {16'h0, e[15:0]});
        chk("overflow", {31'h0, bus.overflow}, {31'h0, e[16]});
        chk("year_7seg", {4'h0, bus.year_7seg}, {4'h0, seg_word(e[15:0])});
        chk("busy_at_done", {31'h0, bus.busy}, 32'h0);
      end
    end
  end

  // One conversion; if rej_at > 0 a rejected start with rej_year is pulsed that many cycles in.
  task automatic do_conv(input logic [13:0] y, input logic [15:0] exp_bcd, input logic exp_ovf,
                         input int rej_at, input logic [13:0] rej_year);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.year_bin = y;
    exp_q.push_back({exp_ovf, exp_bcd});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_accept", {31'h0, bus.busy}, 32'h1);
    chk("overflow_after_accept", {31'h0, bus.overflow}, {31'h0, exp_ovf});
    lat = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) busy_cnt++;
      if (rej_at > 0 && lat == rej_at) begin
        bus.start    = 1'b1;
        bus.year_bin = rej_year;
      end else if (rej_at > 0 && lat == rej_at + 1) begin
        bus.start = 1'b0;
      end
    end
    chk("latency", lat, 14);
    chk("busy_cycles", busy_cnt, 14);
  endtask

  task automatic held_start(input logic [13:0] ys[4], input logic [15:0] bcds[4]);
    int n;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.year_bin = ys[0];
    exp_q.push_back({1'b0, bcds[0]});
    for (int i = 1; i <= 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.done && n < 40);
      chk("b2b_period", n, 15);
      if (i < 4) begin
        bus.year_bin = ys[i];
        exp_q.push_back({1'b0, bcds[i]});
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic [13:0] ys[4];
    logic [15:0] bcds[4];
    bus.start    = 1'b0;
    bus.year_bin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_digits", {16'h0, dut_digits()}, 32'h0001);
    chk("reset_7seg", {4'h0, bus.year_7seg}, {4'h0, 7'h3F, 7'h3F, 7'h3F, 7'h06});
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    chk("reset_done", {31'h0, bus.done}, 32'h0);
    chk("reset_overflow", {31'h0, bus.overflow}, 32'h0);
    chk("reset_state", {31'h0, bus.state_dbg}, 32'h0);

    do_conv(14'd2024, 16'h2024, 1'b0, 0, 14'd0);
    do_conv(14'd0, 16'h0000, 1'b0, 0, 14'd0);
    do_conv(14'd9999, 16'h9999, 1'b0, 0, 14'd0);
    do_conv(14'd1, 16'h0001, 1'b0, 0, 14'd0);
    do_conv(14'd12000, 16'h9999, 1'b1, 0, 14'd0);
    do_conv(14'd500, 16'h0500, 1'b0, 0, 14'd0);
    do_conv(14'd1999, 16'h1999, 1'b0, 5, 14'd3000);
    idle_cycles(20);

    ys   = '{14'd100, 14'd8765, 14'd4321, 14'd37};
    bcds = '{16'h0100, 16'h8765, 16'h4321, 16'h0037};
    held_start(ys, bcds);
    idle_cycles(3);

    // Abort in the middle of a conversion.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.year_bin = 14'd2024;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    idle_cycles(6);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_digits", {16'h0, dut_digits()}, 32'h0001);
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    chk("abort_overflow", {31'h0, bus.overflow}, 32'h0);
    chk("abort_7seg", {4'h0, bus.year_7seg}, {4'h0, 7'h3F, 7'h3F, 7'h3F, 7'h06});
    idle_cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(20);
    do_conv(14'd2025, 16'h2025, 1'b0, 0, 14'd0);
    idle_cycles(3);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
